absorb: RTL
===========

ABSORB -- requirements
Module: absorb

Interface
REQ-001 SHALL have parameter CWIDTH, default 320, capacity width in bits.
REQ-002 SHALL have parameter RWIDTH, default 32, rate width in bits, a multiple of 8.
REQ-003 SHALL have parameter BWIDTH, default $clog2(RWIDTH/8)+1, msg_bytes width.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-006 SHALL have port start, input, 1, begins absorption; honored only in IDLE.
REQ-007 SHALL have ports r_init and c_init, inputs, RWIDTH and CWIDTH, initial sponge state.
REQ-008 SHALL have ports msg_valid (input, 1), msg_ready (output, 1) and msg_data (input, RWIDTH), the message word handshake.
REQ-009 SHALL have ports msg_last (input, 1) and msg_bytes (input, BWIDTH), the final-word flag and the valid-byte count.
REQ-010 SHALL have ports perm_go (output, 1), perm_r (output, RWIDTH) and perm_c (output, CWIDTH), the permutation request.
REQ-011 SHALL have ports perm_done (input, 1), perm_r_in (input, RWIDTH) and perm_c_in (input, CWIDTH), the permutation result.
REQ-012 SHALL have ports r_out (output, RWIDTH) and c_out (output, CWIDTH), the absorbed state fed to squeez.
REQ-013 SHALL have ports absorbDone (output, 1, one-cycle pulse) and busy (output, 1, high when not IDLE).

Function
REQ-014 SHALL implement FSM states IDLE, WAIT_MSG, PERM_GO, PERM_WAIT, PAD, DONE.
REQ-015 In IDLE with start=1, SHALL latch r_init/c_init into internal rReg/cReg and move to WAIT_MSG.
REQ-016 SHALL drive msg_ready=1 only in WAIT_MSG; a word is accepted on the edge where msg_valid and msg_ready are both 1.
REQ-017 On acceptance, SHALL set rReg <= rReg XOR word, with byte 0 of the word in bits [RWIDTH-1:RWIDTH-8], and move to PERM_GO.
REQ-018 In PERM_GO, SHALL assert perm_go for exactly one cycle, with perm_r=rReg and perm_c=cReg, then move to PERM_WAIT.
REQ-019 In PERM_WAIT, SHALL hold perm_r/perm_c stable and wait for perm_done=1, which is only sampled in this state.
REQ-020 On perm_done, SHALL latch perm_r_in/perm_c_in into rReg/cReg and then:
- if the last word is not yet absorbed, go to WAIT_MSG;
- if an extra pad block is pending, go to PAD;
- otherwise go to DONE.
REQ-021 In DONE, SHALL pulse absorbDone for one cycle and return to IDLE; r_out/c_out continuously reflect rReg/cReg.
REQ-022 start SHALL be ignored in every state except IDLE.
REQ-023 msg_bytes SHALL be sampled only with an accepted last word; values above RWIDTH/8 are treated as RWIDTH/8.

Reset
REQ-024 reset=1 at a clock edge SHALL force IDLE, clear rReg and cReg, and set all outputs to 0, including msg_ready, perm_go, absorbDone and busy.
REQ-025 Reset mid-operation SHALL abandon the message; a perm_done arriving after reset SHALL be ignored.

Configuration
REQ-026 Macro ABSORB_PAD_EN defined: the block SHALL apply 10* padding.
- For a last word with k<RWIDTH/8 bytes, it SHALL keep the top 8k bits, place 0x80 in byte k, and zero the remaining bytes before the XOR.
- For k=RWIDTH/8, it SHALL absorb the word unmodified, then in PAD XOR 0x80 into byte 0 of rReg and run one more PERM_GO/PERM_WAIT before DONE.
REQ-027 Macro ABSORB_PAD_EN undefined: the block SHALL ignore msg_bytes, XOR every word in full, never enter PAD, and treat the caller as supplying pre-padded blocks.

Verification
(Benches use RWIDTH=32, CWIDTH=320 and an identity permutation stub with perm_done 3 cycles after perm_go.)
REQ-028 PAD_EN, r_init=0, c_init=0, word 0x11223344 last, bytes=4 -> two perm_go pulses, r_out=0x91223344, one absorbDone pulse.
REQ-029 PAD_EN, word 0xAABBCCDD last, bytes=2 -> one perm_go, r_out=0xAABB8000.
REQ-030 PAD_EN, word 0xFFFFFFFF last, bytes=0 -> one perm_go, r_out=0x80000000.
REQ-031 PAD_EN, words 1, 2, 3 (last, bytes=4) with msg_valid gaps -> msg_ready low outside WAIT_MSG, four perm_go pulses, r_out=0x80000000.
REQ-032 reset asserted during PERM_WAIT -> next cycle all outputs 0, busy=0; the late perm_done causes no state change; start still ignored until reset deasserts.
REQ-033 ABSORB_PAD_EN undefined, word 0x11223344 last, bytes=2 -> one perm_go, r_out=0x11223344.

Source files
------------

// File: rtl/absorb_if.sv
// absorb_if -- message word handshake between a producer and the absorb block.
//   msg_valid : producer has a word on msg_data
//   msg_ready : absorb can take a word this cycle
//   msg_data  : message word, byte 0 in the most significant byte
//   msg_last  : this word is the final word of the message
//   msg_bytes : number of valid bytes in the final word
interface absorb_if #(
  parameter int RWIDTH = 32,
  parameter int BWIDTH = $clog2(RWIDTH/8) + 1
) ();
  logic              msg_valid;
  logic              msg_ready;
  logic [RWIDTH-1:0] msg_data;
  logic              msg_last;
  logic [BWIDTH-1:0] msg_bytes;

  modport master (
    output msg_valid, msg_data, msg_last, msg_bytes,
    input  msg_ready
  );

  modport slave (
    input  msg_valid, msg_data, msg_last, msg_bytes,
    output msg_ready
  );
endinterface

// File: rtl/absorb.sv
// absorb -- sponge absorb phase controller.
// XORs each accepted message word into the rate part of the sponge state and
// hands the whole state to an external permutation after every word.
// Optional 10* padding is compiled in with the macro ABSORB_PAD_EN; without it
// the caller supplies pre-padded blocks and msg_bytes is ignored.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   start, r_init, c_init: begin absorption from the given initial state (IDLE only)
//   msg (absorb_if.slave): message word handshake
//   perm_go/perm_r/perm_c: one-cycle permutation request with the state to permute
//   perm_done/perm_r_in/perm_c_in : permutation result
//   r_out, c_out         : current state (final absorbed state after absorbDone)
//   absorbDone, busy     : completion pulse, not-IDLE indicator
module absorb #(
  parameter int CWIDTH = 320,
  parameter int RWIDTH = 32,
  parameter int BWIDTH = $clog2(RWIDTH/8) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [RWIDTH-1:0] r_init,
  input  logic [CWIDTH-1:0] c_init,
  absorb_if.slave           msg,
  output logic              perm_go,
  output logic [RWIDTH-1:0] perm_r,
  output logic [CWIDTH-1:0] perm_c,
  input  logic              perm_done,
  input  logic [RWIDTH-1:0] perm_r_in,
  input  logic [CWIDTH-1:0] perm_c_in,
  output logic [RWIDTH-1:0] r_out,
  output logic [CWIDTH-1:0] c_out,
  output logic              absorbDone,
  output logic              busy
);

  localparam int NB = RWIDTH / 8;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_MSG  = 3'd1;
  localparam logic [2:0] ST_PERM_GO   = 3'd2;
  localparam logic [2:0] ST_PERM_WAIT = 3'd3;
  localparam logic [2:0] ST_PAD       = 3'd4;
  localparam logic [2:0] ST_DONE      = 3'd5;

  logic [2:0]        state_r, state_s;
  logic [RWIDTH-1:0] r_state_r, r_state_s;
  logic [CWIDTH-1:0] c_state_r, c_state_s;
  logic              last_seen_r, last_seen_s;
  logic              msg_ready_r, perm_go_r, done_r, busy_r;

`ifdef ABSORB_PAD_EN
  logic              pad_pend_r, pad_pend_s;

  // Keep bytes 0..k-1, put the 0x80 pad marker in byte k, zero the rest.
  function automatic logic [RWIDTH-1:0] pad_word(input logic [RWIDTH-1:0] w, input int k);
    logic [RWIDTH-1:0] p;
    p = '0;
    for (int i = 0; i < NB; i++) begin
      if (i < k) begin
        p[RWIDTH-1-8*i -: 8] = w[RWIDTH-1-8*i -: 8];
      end else if (i == k) begin
        p[RWIDTH-1-8*i -: 8] = 8'h80;
      end else begin
        p[RWIDTH-1-8*i -: 8] = 8'h00;
      end
    end
    return p;
  endfunction
`endif

  // Next-state and next-datapath decode.
  always_comb begin
    state_s     = state_r;
    r_state_s   = r_state_r;
    c_state_s   = c_state_r;
    last_seen_s = last_seen_r;
`ifdef ABSORB_PAD_EN
    pad_pend_s  = pad_pend_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s     = ST_WAIT_MSG;
          r_state_s   = r_init;
          c_state_s   = c_init;
          last_seen_s = 1'b0;
`ifdef ABSORB_PAD_EN
          pad_pend_s  = 1'b0;
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT_MSG: begin
        // msg_ready is high exactly while in this state, so valid alone accepts.
        if (msg.msg_valid) begin
          state_s     = ST_PERM_GO;
          last_seen_s = msg.msg_last;
`ifdef ABSORB_PAD_EN
          // Oversized byte counts behave like a full word.
          if (msg.msg_last && (int'(msg.msg_bytes) < NB)) begin
            r_state_s  = r_state_r ^ pad_word(msg.msg_data, int'(msg.msg_bytes));
            pad_pend_s = 1'b0;
          end else begin
            r_state_s  = r_state_r ^ msg.msg_data;
            pad_pend_s = msg.msg_last;
          end
`else
          r_state_s   = r_state_r ^ msg.msg_data;
`endif
        end else begin
          state_s = ST_WAIT_MSG;
        end
      end
      ST_PERM_GO: begin
        state_s = ST_PERM_WAIT;
      end
      ST_PERM_WAIT: begin
        if (perm_done) begin
          r_state_s = perm_r_in;
          c_state_s = perm_c_in;
          if (!last_seen_r) begin
            state_s = ST_WAIT_MSG;
`ifdef ABSORB_PAD_EN
          end else if (pad_pend_r) begin
            state_s = ST_PAD;
`endif
          end else begin
            state_s = ST_DONE;
          end
        end else begin
          state_s = ST_PERM_WAIT;
        end
      end
`ifdef ABSORB_PAD_EN
      ST_PAD: begin
        // Full last word: the pad marker goes alone into an extra block.
        r_state_s = r_state_r ^ {8'h80, {(RWIDTH-8){1'b0}}};
        pad_pend_s = 1'b0;
        state_s    = ST_PERM_GO;
      end
`endif
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output registers; outputs are decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      r_state_r   <= '0;
      c_state_r   <= '0;
      last_seen_r <= 1'b0;
      msg_ready_r <= 1'b0;
      perm_go_r   <= 1'b0;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
`ifdef ABSORB_PAD_EN
      pad_pend_r  <= 1'b0;
`endif
    end else begin
      state_r     <= state_s;
      r_state_r   <= r_state_s;
      c_state_r   <= c_state_s;
      last_seen_r <= last_seen_s;
      msg_ready_r <= (state_s == ST_WAIT_MSG);
      perm_go_r   <= (state_s == ST_PERM_GO);
      done_r      <= (state_s == ST_DONE);
      busy_r      <= (state_s != ST_IDLE);
`ifdef ABSORB_PAD_EN
      pad_pend_r  <= pad_pend_s;
`endif
    end
  end

  assign msg.msg_ready = msg_ready_r;
  assign perm_go       = perm_go_r;
  assign perm_r        = r_state_r;
  assign perm_c        = c_state_r;
  assign r_out         = r_state_r;
  assign c_out         = c_state_r;
  assign absorbDone    = done_r;
  assign busy          = busy_r;

endmodule
